fifo_1r1w: RTL and testbench



---
 rtl/fifo_1r1w_pkg.sv | 22 ++
 rtl/fifo_1r1w_ram.sv | 37 +++
 rtl/fifo_1r1w.sv | 96 +++++++++
 tb/tb_fifo_1r1w.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/fifo_1r1w_pkg.sv
// Shared constants and helpers for the 1R1W circular FIFO.
// Pointer arithmetic lives here so the controller and RAM agree on depth.
package fifo_1r1w_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 2;
  localparam int unsigned FIFO_DEPTH     = 1 << ADDR_WIDTH_DEF;
  localparam int unsigned CNT_WIDTH      = ADDR_WIDTH_DEF + 1;

  function automatic int unsigned fifo_depth(
    input int unsigned aw
  );
    return 1 << aw;
  endfunction

  function automatic int unsigned ptr_inc(
    input int unsigned p,
    input int unsigned aw
  );
    return (p + 1) & ((1 << aw) - 1);
  endfunction

endpackage

// File: rtl/fifo_1r1w_ram.sv
// 1-read/1-write register RAM; async read, gwe-gated write and clear.
// Module name ram_1r1w is the storage shared by pipeline FIFOs.
module ram_1r1w
  import fifo_1r1w_pkg::*;
#(
  parameter int bit_width  = 16,
  parameter int addr_width = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gwe,
  input  logic                  we,
  input  logic [addr_width-1:0] wsel,
  input  logic [bit_width-1:0]  wdata,
  input  logic [addr_width-1:0] rsel,
  output logic [bit_width-1:0]  rdata
);

  localparam int unsigned DEPTH = fifo_depth(addr_width);

  logic [bit_width-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (gwe) begin
      if (rst) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          mem[i] <= '0;
        end
      end else if (we) begin
        mem[wsel] <= wdata;
      end
    end
  end

  assign rdata = mem[rsel];

endmodule

// File: rtl/fifo_1r1w.sv
// Circular FIFO controller: head/tail/count around a ram_1r1w.
// All state is frozen while gwe is low.
module fifo_1r1w
  import fifo_1r1w_pkg::*;
#(
  parameter int bit_width  = 16,
  parameter int addr_width = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  gwe,
  input  logic                  flush,
  input  logic                  enq_valid,
  input  logic [bit_width-1:0]  enq_data,
  output logic                  enq_ready,
  output logic                  deq_valid,
  output logic [bit_width-1:0]  deq_data,
  input  logic                  deq_ready,
  output logic [addr_width:0]   count
);

  localparam logic [addr_width:0] DEPTH_C =
    (addr_width+1)'(fifo_depth(addr_width));
  localparam logic [addr_width:0] ONE_C =
    (addr_width+1)'(1);

  logic [addr_width-1:0] head_q;
  logic [addr_width-1:0] tail_q;
  logic [addr_width:0]   cnt_q;
  logic [addr_width-1:0] head_inc;
  logic [addr_width-1:0] tail_inc;
  logic [addr_width-1:0] head_nx;
  logic [addr_width-1:0] tail_nx;
  logic [addr_width:0]   cnt_nx;
  logic                  full;
  logic                  empty;
  logic                  enq_fire;
  logic                  deq_fire;

  assign full     = (cnt_q == DEPTH_C);
  assign empty    = (cnt_q == '0);
  assign enq_fire = gwe & enq_valid & ~full;
  assign deq_fire = gwe & deq_ready & ~empty;

  assign head_inc =
    addr_width'(ptr_inc(32'(head_q), addr_width));
  assign tail_inc =
    addr_width'(ptr_inc(32'(tail_q), addr_width));

  always_comb begin
    head_nx = head_q;
    tail_nx = tail_q;
    cnt_nx  = cnt_q;
    if (deq_fire) head_nx = head_inc;
    if (enq_fire) tail_nx = tail_inc;
    case ({enq_fire, deq_fire})
      2'b10:   cnt_nx = cnt_q + ONE_C;
      2'b01:   cnt_nx = cnt_q - ONE_C;
      default: cnt_nx = cnt_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (gwe) begin
      if (rst || flush) begin
        head_q <= '0;
        tail_q <= '0;
        cnt_q  <= '0;
      end else begin
        head_q <= head_nx;
        tail_q <= tail_nx;
        cnt_q  <= cnt_nx;
      end
    end
  end

  // Write strobe ignores flush; the slot is unreachable once pointers reset.
  ram_1r1w #(
    .bit_width (bit_width),
    .addr_width(addr_width)
  ) u_ram (
    .clk  (clk),
    .rst  (rst),
    .gwe  (gwe),
    .we   (enq_valid & ~full),
    .wsel (tail_q),
    .wdata(enq_data),
    .rsel (head_q),
    .rdata(deq_data)
  );

  assign enq_ready = ~full;
  assign deq_valid = ~empty;
  assign count     = cnt_q;

endmodule

// File: tb/tb_fifo_1r1w.sv
// Directed plus random bench for fifo_1r1w against a queue model.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_fifo_1r1w;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        gwe;
  logic        flush;
  logic        enq_valid;
  logic [15:0] enq_data;
  logic        enq_ready;
  logic        deq_valid;
  logic [15:0] deq_data;
  logic        deq_ready;
  logic [2:0]  count;

  int checks = 0;
  int errors = 0;

  logic [15:0] q [$];

  fifo_1r1w #(
    .bit_width (16),
    .addr_width(2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .gwe      (gwe),
    .flush    (flush),
    .enq_valid(enq_valid),
    .enq_data (enq_data),
    .enq_ready(enq_ready),
    .deq_valid(deq_valid),
    .deq_data (deq_data),
    .deq_ready(deq_ready),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic chk(
    input string       tag,
    input logic [31:0] obs,
    input logic [31:0] exp
  );
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(
    input logic        g,
    input logic        r,
    input logic        f,
    input logic        ev,
    input logic [15:0] ed,
    input logic        dr
  );
    bit enq_f;
    bit deq_f;
    gwe       = g;
    rst       = r;
    flush     = f;
    enq_valid = ev;
    enq_data  = ed;
    deq_ready = dr;
    enq_f = g && ev && (q.size() < DEPTH);
    deq_f = g && dr && (q.size() > 0);
    @(posedge clk);
    if (g) begin
      if (r || f) begin
        q.delete();
      end else begin
        if (deq_f) void'(q.pop_front());
        if (enq_f) q.push_back(ed);
      end
    end
    #1;
    chk("count", 32'(count), q.size());
    chk("enq_ready", 32'(enq_ready), 32'(q.size() < DEPTH));
    chk("deq_valid", 32'(deq_valid), 32'(q.size() > 0));
    if (q.size() > 0) chk("deq_data", 32'(deq_data), 32'(q[0]));
    if (g && r) chk("rst_data", 32'(deq_data), 32'h0);
  endtask

  initial begin
    logic [15:0] hold;
    rst = 0; gwe = 0; flush = 0;
    enq_valid = 0; enq_data = 0; deq_ready = 0;
    @(posedge clk);
    #1;

    // reset then fill, fifth enqueue dropped
    step(1, 1, 0, 0, 16'h0, 0);
    step(1, 0, 0, 1, 16'h1111, 0);
    step(1, 0, 0, 1, 16'h2222, 0);
    step(1, 0, 0, 1, 16'h3333, 0);
    step(1, 0, 0, 1, 16'h4444, 0);
    chk("full_count", 32'(count), 32'd4);
    step(1, 0, 0, 1, 16'h5555, 0);
    chk("fifth_head", 32'(deq_data), 32'h1111);

    // drain with wrap
    step(1, 0, 0, 0, 16'h0, 1);
    step(1, 0, 0, 0, 16'h0, 1);
    step(1, 0, 0, 1, 16'hAAAA, 0);
    step(1, 0, 0, 1, 16'hBBBB, 0);
    chk("wrap_head", 32'(deq_data), 32'h3333);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 0, 16'h0, 1);
    chk("drained", 32'(deq_valid), 32'h0);

    // full with both sides active: only dequeue fires
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, 16'(16'h0200 + i), 0);
    step(1, 0, 0, 1, 16'h0999, 1);
    chk("full_both", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 16'h0, 1);

    // steady state at count 2
    step(1, 0, 0, 1, 16'h0100, 0);
    step(1, 0, 0, 1, 16'h0101, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 0, 1, 16'(16'h0102 + i), 1);
      chk("steady_data", 32'(deq_data), 32'(16'h0101 + i));
    end

    // gwe low freezes everything
    hold = deq_data;
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 1, 16'hDEAD, 1);
      chk("gwe_hold", 32'(deq_data), 32'(hold));
    end

    // flush at count 3 with an enqueue offered
    step(1, 0, 0, 1, 16'h0300, 0);
    step(1, 0, 1, 1, 16'h7777, 0);
    chk("flush_cnt", 32'(count), 32'd0);
    step(1, 0, 0, 1, 16'h0042, 0);
    chk("post_flush", 32'(deq_data), 32'h0042);
    step(1, 0, 0, 0, 16'h0, 1);

    // empty: enqueue and deq_ready together, no bypass
    step(1, 0, 0, 1, 16'h0099, 1);
    chk("nobypass", 32'(count), 32'd1);

    // randomized traffic
    for (int i = 0; i < 500; i++) begin
      step($urandom_range(0, 9) != 0,
           $urandom_range(0, 60) == 0,
           $urandom_range(0, 40) == 0,
           1'($urandom),
           16'($urandom),
           1'($urandom));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
